// File: rtl/core_ctrl_pkg.sv
// Shared types for the core run-control sequencer.
package core_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_CORE_RST = 2'd0,
        ST_HALTED   = 2'd1,
        ST_RUN      = 2'd2,
        ST_STEP     = 2'd3
    } run_state_t;

    typedef enum logic [1:0] {
        OP_RUN        = 2'd0,
        OP_HALT       = 2'd1,
        OP_STEP       = 2'd2,
        OP_RESET_CORE = 2'd3
    } cmd_op_t;

    // A STEP of zero instructions still executes one.
    function automatic logic [15:0] step_load(input logic [15:0] count);
        return (count == 16'd0) ? 16'd1 : count;
    endfunction

endpackage

// File: rtl/clk_enable_gen.sv
// Instruction-period divider: one clk_enable_n mid-period, one clk_enable at the end.
module clk_enable_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic period_start,
    output logic en_n,
    output logic en
);
    localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);
    localparam logic [W-1:0] HALF = W'(DIV / 2 - 1);

    logic [W-1:0] div_cnt;

    // Period counter; held at zero while not running so a new run starts a full period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            div_cnt <= '0;
        else if (clear)
            div_cnt <= '0;
        else if (run)
            div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + W'(1);
    end

    assign period_start = run && (div_cnt == '0);
    assign en_n         = run && (div_cnt == HALF);
    assign en           = run && (div_cnt == LAST);

endmodule

// File: rtl/core_run_ctrl.sv
// Run-control sequencer: core reset, RUN/HALT/STEP, PC breakpoint, retire counter.
module core_run_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int DIV        = 4,
    parameter int RST_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_count,
    input  logic        bp_enable,
    input  logic [31:0] bp_addr,
    input  logic [31:0] pc,
    output logic        core_clk_enable,
    output logic        core_clk_enable_n,
    output logic        core_reset,
    output logic [1:0]  run_state,
    output logic        bp_hit,
    output logic [31:0] retired_count
);
    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

    run_state_t    state, state_n;
    logic [RW-1:0] rst_cnt, rst_cnt_n;
    logic [15:0]   step_left, step_left_n;
    logic          stop_pending, stop_pending_n;
    logic          first_period, first_period_n;
    logic          bp_hit_n;
    logic [31:0]   retired_n;

    logic running, period_start, hs, bp_match, halt_req;
    cmd_op_t op;

    assign running = (state == ST_RUN) || (state == ST_STEP);

    clk_enable_gen #(.DIV(DIV)) u_gen (
        .clk          (clk),
        .rst_n        (reset),
        .clear        (!running),
        .run          (running),
        .period_start (period_start),
        .en_n         (core_clk_enable_n),
        .en           (core_clk_enable)
    );

    assign core_reset = (state == ST_CORE_RST);
    assign cmd_ready  = (state == ST_HALTED) || (state == ST_RUN);
    assign run_state  = state;

    assign hs       = cmd_valid && cmd_ready;
    assign op       = cmd_op_t'(cmd_op);
    // The first period after entry is exempt so the core can resume off a breakpoint.
    assign bp_match = bp_enable && (pc == bp_addr) && period_start && !first_period;
    assign halt_req = stop_pending || (hs && op == OP_HALT);

    // Next-state and datapath updates for the sequencer.
    always_comb begin
        state_n        = state;
        rst_cnt_n      = rst_cnt;
        step_left_n    = step_left;
        stop_pending_n = stop_pending;
        first_period_n = first_period;
        bp_hit_n       = hs ? 1'b0 : bp_hit;
        unique case (state)
            ST_CORE_RST: begin
                if (rst_cnt == RST_LAST) begin
                    state_n   = ST_HALTED;
                    rst_cnt_n = '0;
                end else begin
                    rst_cnt_n = rst_cnt + RW'(1);
                end
            end
            ST_HALTED: begin
                if (hs) begin
                    unique case (op)
                        OP_RUN: begin
                            state_n        = ST_RUN;
                            first_period_n = 1'b1;
                        end
                        OP_STEP: begin
                            state_n        = ST_STEP;
                            step_left_n    = step_load(cmd_count);
                            first_period_n = 1'b1;
                        end
                        OP_RESET_CORE: begin
                            state_n   = ST_CORE_RST;
                            rst_cnt_n = '0;
                        end
                        OP_HALT: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (hs && op == OP_RESET_CORE) begin
                    state_n        = ST_CORE_RST;
                    rst_cnt_n      = '0;
                    stop_pending_n = 1'b0;
                end else begin
                    stop_pending_n = halt_req;
                    if (bp_match) begin
                        state_n        = ST_HALTED;
                        bp_hit_n       = 1'b1;
                        stop_pending_n = 1'b0;
                    end else if (core_clk_enable) begin
                        first_period_n = 1'b0;
                        if (halt_req) begin
                            state_n        = ST_HALTED;
                            stop_pending_n = 1'b0;
                        end
                    end
                end
            end
            ST_STEP: begin
                if (bp_match) begin
                    state_n     = ST_HALTED;
                    bp_hit_n    = 1'b1;
                    step_left_n = '0;
                end else if (core_clk_enable) begin
                    first_period_n = 1'b0;
                    step_left_n    = step_left - 16'd1;
                    if (step_left == 16'd1)
                        state_n = ST_HALTED;
                end
            end
        endcase
        retired_n = retired_count + (core_clk_enable ? 32'd1 : 32'd0);
        if (state_n == ST_CORE_RST && state != ST_CORE_RST)
            retired_n = '0;
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_CORE_RST;
            rst_cnt       <= '0;
            step_left     <= '0;
            stop_pending  <= 1'b0;
            first_period  <= 1'b0;
            bp_hit        <= 1'b0;
            retired_count <= '0;
        end else begin
            state         <= state_n;
            rst_cnt       <= rst_cnt_n;
            step_left     <= step_left_n;
            stop_pending  <= stop_pending_n;
            first_period  <= first_period_n;
            bp_hit        <= bp_hit_n;
            retired_count <= retired_n;
        end
    end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Self-checking bench: expected pulse schedules are computed arithmetically from accept edges.
module tb_core_run_ctrl;
    import core_ctrl_pkg::*;

    localparam int DIV        = 4;
    localparam int RST_CYCLES = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [15:0] cmd_count = 16'd0;
    logic        bp_enable = 1'b0;
    logic [31:0] bp_addr = 32'd0;
    logic [31:0] pc = 32'd0;
    logic        core_clk_enable, core_clk_enable_n, core_reset, bp_hit;
    logic [1:0]  run_state;
    logic [31:0] retired_count;

    core_run_ctrl #(.DIV(DIV), .RST_CYCLES(RST_CYCLES)) dut (
        .clk               (clk),
        .reset             (reset),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_op            (cmd_op),
        .cmd_count         (cmd_count),
        .bp_enable         (bp_enable),
        .bp_addr           (bp_addr),
        .pc                (pc),
        .core_clk_enable   (core_clk_enable),
        .core_clk_enable_n (core_clk_enable_n),
        .core_reset        (core_reset),
        .run_state         (run_state),
        .bp_hit            (bp_hit),
        .retired_count     (retired_count)
    );

    always #5 clk = ~clk;

    int n_asrt = 0;
    int n_fail = 0;
    int cyc = 0;          // edges seen; outputs sampled 1ns after edge cyc
    int pulses[$];        // cyc values where core_clk_enable was high
    int npulses[$];       // cyc values where core_clk_enable_n was high
    int exp_retired = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; the emulated core advances pc by 4 per retired instruction.
    task automatic tick();
        logic en_prev;
        en_prev = core_clk_enable;
        @(posedge clk);
        #1;
        cyc++;
        if (en_prev === 1'b1) pc = pc + 32'd4;
        if (core_clk_enable === 1'b1) pulses.push_back(cyc);
        if (core_clk_enable_n === 1'b1) npulses.push_back(cyc);
    endtask

    task automatic send(input cmd_op_t op, input logic [15:0] cnt, output int acc);
        bit rdy;
        int tries;
        tries = 0;
        acc = -1;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_count = cnt;
        while (acc < 0 && tries < 50) begin
            rdy = cmd_ready;
            tick();
            tries++;
            if (rdy) acc = cyc;
        end
        cmd_valid = 1'b0;
        chk("cmd_accept", 32'(acc >= 0), 32'd1);
    endtask

    task automatic count_rst(output int n);
        n = (core_reset === 1'b1) ? 1 : 0;
        while (core_reset === 1'b1 && n < 40) begin
            tick();
            if (core_reset === 1'b1) n++;
        end
    endtask

    // HALT after a RUN accepted at cyc a: the last pulse is the first period end at/after the HALT.
    task automatic halt_and_check(input int a, input string tag);
        int h, m, last;
        send(OP_HALT, 16'd0, h);
        m = (h - a + DIV - 1) / DIV;
        last = a + m * DIV - 1;
        while (cyc < last) tick();
        if (cyc == last) chk({tag, "_state_last"}, 32'(run_state), 32'(ST_RUN));
        while (cyc < last + 1) tick();
        chk({tag, "_halted"}, 32'(run_state), 32'(ST_HALTED));
        chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        repeat (2 * DIV) tick();
        chk({tag, "_npulses"}, pulses.size(), m);
        chk({tag, "_nen_n"}, npulses.size(), m);
        if (pulses.size() > 0) begin
            chk({tag, "_first_en"}, pulses[0], a + DIV - 1);
            chk({tag, "_last_en"}, pulses[$], last);
        end
        if (npulses.size() > 0) chk({tag, "_first_en_n"}, npulses[0], a + DIV / 2 - 1);
        exp_retired += m;
        chk({tag, "_retired"}, retired_count, exp_retired);
    endtask

    task automatic run_halt(input int d);
        int a;
        pulses.delete();
        npulses.delete();
        send(OP_RUN, 16'd0, a);
        repeat (d) tick();
        halt_and_check(a, "run");
    endtask

    task automatic step_n(input int cnt);
        int a, n, bad;
        pulses.delete();
        npulses.delete();
        bad = 0;
        send(OP_STEP, 16'(cnt), a);
        n = (cnt == 0) ? 1 : cnt;
        while (cyc < a + n * DIV) begin
            if (cmd_ready !== 1'b0) bad++;
            tick();
        end
        chk("step_halted", 32'(run_state), 32'(ST_HALTED));
        chk("step_ready_low", bad, 0);
        chk("step_npulses", pulses.size(), n);
        if (pulses.size() > 0) chk("step_last_en", pulses[$], a + n * DIV - 1);
        exp_retired += n;
        chk("step_retired", retired_count, exp_retired);
    endtask

    initial begin
        int a, h, n;

        // Power-on reset
        tick();
        tick();
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_en", 32'(core_clk_enable), 32'd0);
        chk("rst_en_n", 32'(core_clk_enable_n), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_bp_hit", 32'(bp_hit), 32'd0);
        chk("rst_retired", retired_count, 32'd0);
        chk("rst_state", 32'(run_state), 32'(ST_CORE_RST));
        reset = 1'b1;
        pulses.delete();
        npulses.delete();
        count_rst(n);
        chk("rst_len", n, RST_CYCLES);
        chk("rst_no_pulses", pulses.size() + npulses.size(), 0);
        chk("rst_to_halted", 32'(run_state), 32'(ST_HALTED));
        chk("halted_ready", 32'(cmd_ready), 32'd1);

        // Directed RUN then HALT nine edges later
        run_halt(8);

        // HALT while halted is a no-op
        send(OP_HALT, 16'd0, a);
        tick();
        chk("halt_noop", 32'(run_state), 32'(ST_HALTED));

        step_n(3);
        step_n(0);

        // Randomized RUN/HALT delays and STEP counts
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 0) run_halt(int'($urandom_range(0, 20)));
            else step_n(int'($urandom_range(0, 6)));
        end

        // Breakpoint at 0x10 with pc starting from 0
        pc = 32'd0;
        bp_addr = 32'h10;
        bp_enable = 1'b1;
        pulses.delete();
        npulses.delete();
        send(OP_RUN, 16'd0, a);
        n = 0;
        while (run_state !== 2'(ST_HALTED) && n < 200) begin
            tick();
            n++;
        end
        chk("bp_halt_cycle", cyc, a + 4 * DIV + 1);
        chk("bp_npulses", pulses.size(), 4);
        chk("bp_pc", pc, 32'h10);
        chk("bp_hit_set", 32'(bp_hit), 32'd1);
        exp_retired += 4;
        chk("bp_retired", retired_count, exp_retired);
        pulses.delete();
        npulses.delete();
        send(OP_RUN, 16'd0, a);
        chk("bp_hit_clear", 32'(bp_hit), 32'd0);
        repeat (2 * DIV) tick();
        chk("bp_resume_state", 32'(run_state), 32'(ST_RUN));
        chk("bp_resume_pc", pc, 32'h18);
        halt_and_check(a, "bp_resume");
        bp_enable = 1'b0;

        // RESET_CORE in the div_cnt==1 cycle of a period
        pulses.delete();
        npulses.delete();
        send(OP_RUN, 16'd0, a);
        n = 0;
        while (pulses.size() == 0 && n < 50) begin
            tick();
            n++;
        end
        tick();
        tick();
        exp_retired += pulses.size();
        chk("rc_pre_retired", retired_count, exp_retired);
        send(OP_RESET_CORE, 16'd0, h);
        exp_retired = 0;
        chk("rc_retired", retired_count, 32'd0);
        chk("rc_core_reset", 32'(core_reset), 32'd1);
        chk("rc_state", 32'(run_state), 32'(ST_CORE_RST));
        pulses.delete();
        npulses.delete();
        count_rst(n);
        chk("rc_len", n, RST_CYCLES);
        chk("rc_no_pulses", pulses.size() + npulses.size(), 0);
        chk("rc_halted", 32'(run_state), 32'(ST_HALTED));

        // Asynchronous reset in the middle of a STEP
        send(OP_STEP, 16'd5, a);
        repeat (DIV + 1) tick();
        #1 reset = 1'b0;
        #1;
        chk("ar_core_reset", 32'(core_reset), 32'd1);
        chk("ar_en", 32'(core_clk_enable), 32'd0);
        chk("ar_en_n", 32'(core_clk_enable_n), 32'd0);
        chk("ar_ready", 32'(cmd_ready), 32'd0);
        chk("ar_bp_hit", 32'(bp_hit), 32'd0);
        chk("ar_retired", retired_count, 32'd0);
        chk("ar_state", 32'(run_state), 32'(ST_CORE_RST));
        exp_retired = 0;
        reset = 1'b1;
        pulses.delete();
        npulses.delete();
        count_rst(n);
        chk("ar_len", n, RST_CYCLES);
        chk("ar_no_pulses", pulses.size() + npulses.size(), 0);
        step_n(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/core_run_ctrl.md
# core_run_ctrl

Run-control sequencer for the single-cycle RV32I core. Generates the core's `clk_enable`/`clk_enable_n` pulses from the 100 MHz clock, holds the core in reset, and executes RUN / HALT / STEP / RESET_CORE commands from a debug/host port. A PC breakpoint stops execution before the matching instruction retires. Sits between the board-level clock/reset and the core's `clk_enable`, `clk_enable_n` and `reset` inputs.

## Interface
- `DIV`, 4: clk cycles per core instruction period; even, ≥4.
- `RST_CYCLES`, 4: clk cycles `core_reset` is held per core reset.
- `clk` in 1: 100 MHz clock; sole clock.
- `reset` in 1: asynchronous, active-low; one clock; reset is asynchronous and active-low.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready` at a rising edge.
- `cmd_op` in 2: 0 RUN, 1 HALT, 2 STEP, 3 RESET_CORE.
- `cmd_count` in 16: instructions to execute for STEP; 0 is treated as 1.
- `bp_enable` in 1: breakpoint enable.
- `bp_addr` in 32: breakpoint PC.
- `pc` in 32: core's current PC.
- `core_clk_enable` out 1: to core `clk_enable`.
- `core_clk_enable_n` out 1: to core `clk_enable_n`.
- `core_reset` out 1: to core `reset`, active-high.
- `run_state` out 2: 0 CORE_RST, 1 HALTED, 2 RUN, 3 STEP.
- `bp_hit` out 1: sticky, set when a breakpoint halts the core.
- `retired_count` out 32: count of `core_clk_enable` pulses.

## Operation
- FSM states: CORE_RST, HALTED, RUN, STEP.
- CORE_RST: `core_reset`=1 for `RST_CYCLES` cycles, then HALTED. No enable pulses. `cmd_ready`=0.
- HALTED: `cmd_ready`=1. RUN → RUN. STEP → STEP with `step_left`=max(`cmd_count`,1). RESET_CORE → CORE_RST. HALT is a no-op.
- RUN: `cmd_ready`=1. Periods repeat. HALT sets `stop_pending`; the state goes to HALTED after the current period's `core_clk_enable` cycle. RESET_CORE aborts immediately to CORE_RST (partial period allowed). RUN and STEP commands are ignored.
- STEP: `cmd_ready`=0. After each period `step_left` decrements; at 0 the state goes to HALTED.
- Period: divider `div_cnt` counts 0..DIV-1 and is cleared on entry to RUN/STEP.
  - `core_clk_enable_n`=1 only when `div_cnt`==DIV/2-1.
  - `core_clk_enable`=1 only when `div_cnt`==DIV-1.
  - Both are 0 outside RUN/STEP.
- Breakpoint: checked at `div_cnt`==0 of every period except the first after entering RUN/STEP.
  - If `bp_enable && pc==bp_addr`, the period is cancelled (no pulses), the state goes to HALTED and `bp_hit` is set.
  - The first-period exemption lets the core resume from a breakpoint.
- `bp_hit` clears when the next command is accepted.
- `retired_count` increments on each `core_clk_enable` cycle, wraps modulo 2^32, and clears on CORE_RST entry.
- Simultaneous events:
  - HALT accepted in the same cycle as a breakpoint hit → HALTED, `bp_hit`=1.
  - RESET_CORE overrides everything.

## Timing
- Reset values: state CORE_RST, `core_reset`=1, `core_clk_enable`=0, `core_clk_enable_n`=0, `cmd_ready`=0, `bp_hit`=0, `retired_count`=0, `div_cnt`=0, `stop_pending`=0, `step_left`=0.
- Async reset mid-operation forces all reset values immediately. After deassertion, `core_reset` stays 1 for `RST_CYCLES` clks.
- Outputs are decoded from registers only; no combinational path from `cmd_*`/`pc` to outputs.
- Command accepted at edge k (HALTED→RUN/STEP):
  - `core_clk_enable_n` is high in cycle k+DIV/2.
  - `core_clk_enable` is high in cycle k+DIV.
  - Periods are then back to back.
- HALT accepted during a period → last `core_clk_enable` is in that period; `run_state`=HALTED the cycle after.
- STEP n → exactly n `core_clk_enable` pulses, then HALTED the cycle after the last pulse.
- `pc` is sampled at `div_cnt`==0, one cycle after the previous `core_clk_enable`.

## Structure
- Package `core_ctrl_pkg`: `run_state_t` enum, `cmd_op_t` enum (RUN/HALT/STEP/RESET_CORE encodings).
- Sub-module `clk_enable_gen`: the `div_cnt` divider, with sync clear and run inputs, producing the two enable pulses and a `period_start` flag.
- FSM, step counter, breakpoint compare and `retired_count` live in `core_run_ctrl`.

## Test plan
- Reset release, DIV=4, RST_CYCLES=4 → `core_reset` high 4 clks, then HALTED, `cmd_ready`=1, no enable pulses.
- RUN at edge k → `core_clk_enable_n` at k+2, `core_clk_enable` at k+4, k+8, k+12…; HALT accepted at k+9 → last pulse k+12, HALTED at k+13.
- STEP `cmd_count`=3 → exactly 3 `core_clk_enable` pulses, `retired_count`=3, `cmd_ready`=0 throughout; STEP `cmd_count`=0 → 1 pulse.
- `bp_enable`=1, `bp_addr`=0x10, `pc` advancing by 4 per pulse from 0 → halts after 4 pulses with `pc`=0x10, `bp_hit`=1; a second RUN retires the 0x10 instruction without an immediate re-halt.
- RESET_CORE accepted mid-period (`div_cnt`=1) → no further enables, `core_reset` high 4 clks, `retired_count`=0.
- Async `reset` low mid-STEP → all outputs at reset values in the same cycle; normal restart after release.
